// File: rtl/updown_counter_param_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter_param_pkg
//   Shared constants for the parametrised up/down counter family:
//   direction encoding of the up input, encoding of the SATURATE parameter,
//   and a helper that sizes the prescaler phase register.
// -----------------------------------------------------------------------------
package updown_counter_param_pkg;

    // Direction encoding of the up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // SATURATE parameter encoding
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Phase register width: max(1, clog2(prescale))
    function automatic int phaseWidth(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/updown_counter_param_prescale_tick.sv
// -----------------------------------------------------------------------------
// prescale_tick
//   Divides enabled cycles by PRESCALE. tick is high on the enabled cycle in
//   which the phase reaches PRESCALE-1; the phase then wraps to 0. The phase
//   only moves on enabled cycles and is forced to 0 by sync_zero.
//   Ports:
//     i_clk        clock, rising edge
//     i_rst        asynchronous reset, active-high
//     i_en         count enable, advances the phase
//     i_sync_zero  synchronous phase clear (driven by clear | load)
//     o_tick       one step permitted this cycle
// -----------------------------------------------------------------------------
module prescale_tick
    import updown_counter_param_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_sync_zero,
    output logic o_tick
);

    localparam int PW = phaseWidth(PRESCALE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;
    logic          w_atLast;

    // With PRESCALE=1 LAST_PHASE is 0, so the phase never leaves 0 and tick follows en
    assign w_atLast = (r_phase == LAST_PHASE);
    assign o_tick   = i_en & w_atLast;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (i_sync_zero) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= w_atLast ? '0 : r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//   Parametrised up/down counter with wrap or saturate at the boundary,
//   prescaled enable, parallel load, synchronous clear, a registered
//   terminal-count pulse and a sticky overflow/underflow flag.
//   Ports:
//     i_clk       clock, rising edge
//     i_rst       asynchronous reset, active-high
//     i_en        count enable (prescaler advances only while high)
//     i_up        direction: 1 = increment, 0 = decrement
//     i_clr       synchronous clear (highest priority)
//     i_load      synchronous parallel load
//     i_load_val  value to load, clamped to MAX_VAL
//     o_count     registered count
//     o_tc        registered one-cycle terminal-count pulse
//     o_ovf       registered sticky overflow/underflow flag
//     o_zero      count == 0
// -----------------------------------------------------------------------------
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int          SATURATE = 0,
    parameter int          PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    // Value taken by a step that runs into the boundary
    localparam logic [WIDTH-1:0] UP_BOUND_VAL   = (SATURATE == MODE_WRAP) ? '0 : MAX_V;
    localparam logic [WIDTH-1:0] DOWN_BOUND_VAL = (SATURATE == MODE_SAT)  ? '0 : MAX_V;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_countNext;
    logic             w_tcNext;
    logic             w_ovfNext;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_sync_zero (i_clr | i_load),
        .o_tick      (w_tick)
    );

    assign w_step = i_en & w_tick;

    // Next-state mux, priority clr > load > step > hold.
    // Out-of-range counts (above MAX_VAL) are treated as the upper boundary
    // on an up-step and pulled back to MAX_VAL on a down-step.
    always_comb begin
        w_countNext = r_count;
        w_tcNext    = 1'b0;
        w_ovfNext   = r_ovf;
        if (i_clr) begin
            w_countNext = '0;
            w_ovfNext   = 1'b0;
        end else if (i_load) begin
            w_countNext = (i_load_val > MAX_V) ? MAX_V : i_load_val;
        end else if (w_step) begin
            case (i_up)
                DIR_UP: begin
                    if (r_count >= MAX_V) begin
                        w_countNext = UP_BOUND_VAL;
                        w_tcNext    = 1'b1;
                        w_ovfNext   = 1'b1;
                    end else begin
                        w_countNext = r_count + 1'b1;
                    end
                end
                DIR_DOWN: begin
                    if (r_count > MAX_V) begin
                        w_countNext = MAX_V;
                    end else if (r_count == '0) begin
                        w_countNext = DOWN_BOUND_VAL;
                        w_tcNext    = 1'b1;
                        w_ovfNext   = 1'b1;
                    end else begin
                        w_countNext = r_count - 1'b1;
                    end
                end
                default: begin
                    w_countNext = r_count;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_tc    <= w_tcNext;
            r_ovf   <= w_ovfNext;
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_ovf   = r_ovf;
    assign o_zero  = (r_count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//   Drives three counter configurations from shared inputs:
//     0: WIDTH=4, MAX_VAL=9, wrap,     PRESCALE=1
//     1: WIDTH=4, MAX_VAL=9, saturate, PRESCALE=1
//     2: WIDTH=4, MAX_VAL=9, wrap,     PRESCALE=3
//   Expected outputs come from an arithmetic reference model and are queued
//   when stimulus is issued; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

    localparam int NDUT = 3;
    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] loadVal = '0;

    logic [3:0] cntA, cntB, cntC;
    logic       tcA, tcB, tcC;
    logic       ovfA, ovfB, ovfC;
    logic       zeroA, zeroB, zeroC;

    logic [NDUT-1:0][3:0] actCnt;
    logic [NDUT-1:0]      actTc;
    logic [NDUT-1:0]      actOvf;
    logic [NDUT-1:0]      actZero;

    assign actCnt  = {cntC, cntB, cntA};
    assign actTc   = {tcC, tcB, tcA};
    assign actOvf  = {ovfC, ovfB, ovfA};
    assign actZero = {zeroC, zeroB, zeroA};

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) dutA (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(loadVal), .o_count(cntA), .o_tc(tcA), .o_ovf(ovfA), .o_zero(zeroA)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) dutB (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(loadVal), .o_count(cntB), .o_tc(tcB), .o_ovf(ovfB), .o_zero(zeroB)
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) dutC (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clr(clr), .i_load(load),
        .i_load_val(loadVal), .o_count(cntC), .o_tc(tcC), .o_ovf(ovfC), .o_zero(zeroC)
    );

    typedef struct packed {
        logic [NDUT-1:0][3:0] cnt;
        logic [NDUT-1:0]      tc;
        logic [NDUT-1:0]      ovf;
    } expT;

    expT expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: count value, enabled cycles since last tick
    int mCnt[NDUT];
    int mEnCount[NDUT];
    bit mTc[NDUT];
    bit mOvf[NDUT];
    int satCfg[NDUT] = '{0, 1, 0};
    int preCfg[NDUT] = '{1, 1, 3};

    // Single comparison with FAIL report
    task automatic checkOutput(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s[dut%0d]: got %0d, expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < NDUT; k++) begin
            mCnt[k]     = 0;
            mEnCount[k] = 0;
            mTc[k]      = 1'b0;
            mOvf[k]     = 1'b0;
        end
    endfunction

    // One clock edge of the behavioural model for configuration k
    function automatic void modelEdge(input int k, input bit e, input bit u, input bit c,
                                      input bit l, input int lv);
        bit boundary;
        mTc[k] = 1'b0;
        if (c) begin
            mCnt[k] = 0;
            mOvf[k] = 1'b0;
            mEnCount[k] = 0;
        end else if (l) begin
            mCnt[k] = (lv > MAXV) ? MAXV : lv;
            mEnCount[k] = 0;
        end else if (e) begin
            mEnCount[k] = mEnCount[k] + 1;
            if (mEnCount[k] == preCfg[k]) begin
                mEnCount[k] = 0;
                boundary = u ? (mCnt[k] >= MAXV) : (mCnt[k] == 0);
                if (boundary) begin
                    mTc[k] = 1'b1;
                    mOvf[k] = 1'b1;
                    if (u) mCnt[k] = (satCfg[k] != 0) ? MAXV : 0;
                    else   mCnt[k] = (satCfg[k] != 0) ? 0 : MAXV;
                end else if (u) begin
                    mCnt[k] = mCnt[k] + 1;
                end else if (mCnt[k] > MAXV) begin
                    mCnt[k] = MAXV;
                end else begin
                    mCnt[k] = mCnt[k] - 1;
                end
            end
        end
    endfunction

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic applyStimulus(input bit e, input bit u, input bit c, input bit l, input int lv);
        expT ex;
        @(negedge clk);
        en      = e;
        up      = u;
        clr     = c;
        load    = l;
        loadVal = 4'(lv);
        for (int k = 0; k < NDUT; k++) begin
            modelEdge(k, e, u, c, l, lv);
            ex.cnt[k] = 4'(mCnt[k]);
            ex.tc[k]  = mTc[k];
            ex.ovf[k] = mOvf[k];
        end
        expQ.push_back(ex);
    endtask

    // Outputs forced to zero with no clock edge involved
    task automatic checkResetState(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput({tag, "_count"}, k, int'(actCnt[k]), 0);
            checkOutput({tag, "_tc"}, k, int'(actTc[k]), 0);
            checkOutput({tag, "_ovf"}, k, int'(actOvf[k]), 0);
            checkOutput({tag, "_zero"}, k, int'(actZero[k]), 1);
        end
    endtask

    // Monitor: compare after every rising edge that has a queued expectation
    initial begin
        expT ex;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                ex = expQ.pop_front();
                for (int k = 0; k < NDUT; k++) begin
                    checkOutput("count", k, int'(actCnt[k]), int'(ex.cnt[k]));
                    checkOutput("tc", k, int'(actTc[k]), int'(ex.tc[k]));
                    checkOutput("ovf", k, int'(actOvf[k]), int'(ex.ovf[k]));
                    checkOutput("zero", k, int'(actZero[k]), (ex.cnt[k] == 4'd0) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();

        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rst = 1'b0;

        // Wrap through MAX_VAL counting up
        for (int i = 0; i < 11; i++) applyStimulus(1, 1, 0, 0, 0);

        // Saturate down into zero
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);

        // Load clamping, then clear beating load
        applyStimulus(0, 1, 0, 1, 15);
        applyStimulus(1, 1, 1, 1, 5);

        // Prescaler run, pause, resume
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);

        // Asynchronous reset between edges
        applyStimulus(0, 1, 0, 1, 7);
        @(posedge clk);
        #3;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        rst = 1'b1;
        #1;
        checkResetState("async_reset");
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);

        // Wrap below zero and back over MAX_VAL
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            bit c, l, e, u;
            r = int'($urandom_range(0, 99));
            c = (r < 3);
            l = (r >= 3 && r < 10);
            e = ($urandom_range(0, 3) != 0);
            u = ($urandom_range(0, 2) != 0);
            applyStimulus(e, u, c, l, int'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
